// File: rtl/alu_accumulator_if.sv
// alu_accumulator_if
// Groups the sequencer-facing signals of the accumulator execution stage.
//   start  : request to execute op (sampled only when the block is idle)
//   op     : operation code (ADD, SUB, AND, OR, XOR, LOAD, MUL, CLR)
//   b      : operand taken from the operand register's Q output
//   acc    : accumulator / low byte of the product
//   acc_hi : high byte of the product
//   busy   : multiply in progress
//   done   : one-cycle pulse when result and flags are valid
//   z,n,c,v: zero, negative, carry/borrow, signed overflow flags
// The master modport is the sequencer side; the slave modport is the ALU.
interface alu_accumulator_if;
    logic       start;
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] acc;
    logic [7:0] acc_hi;
    logic       busy;
    logic       done;
    logic       z;
    logic       n;
    logic       c;
    logic       v;

    modport master (
        output start, op, b,
        input  acc, acc_hi, busy, done, z, n, c, v
    );

    modport slave (
        input  start, op, b,
        output acc, acc_hi, busy, done, z, n, c, v
    );
endinterface

// File: rtl/alu_accumulator.sv
// alu_accumulator
// 8-bit accumulator execution stage. Single-cycle ADD/SUB/AND/OR/XOR/LOAD/CLR
// update the accumulator and flags on the accepting edge; MUL runs an 8-step
// unsigned shift-add multiply leaving the 16-bit product in {acc_hi, acc}.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, clears all state
//   bus   : slave side of alu_accumulator_if (start/op/b in, results out)
// Every output is driven directly from a flop.
module alu_accumulator (
    input  logic               clk,
    input  logic               reset,
    alu_accumulator_if.slave   bus
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t     state_reg,  state_next;
    logic [3:0] count_reg,  count_next;
    logic [7:0] acc_reg,    acc_next;
    logic [7:0] acc_hi_reg, acc_hi_next;
    logic [7:0] mcand_reg,  mcand_next;
    logic       busy_reg,   busy_next;
    logic       done_reg,   done_next;
    logic       z_reg,      z_next;
    logic       n_reg,      n_next;
    logic       c_reg,      c_next;
    logic       v_reg,      v_next;

    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [8:0]  partial9;
    logic [16:0] shifted;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            count_reg  <= 4'd0;
            acc_reg    <= 8'h00;
            acc_hi_reg <= 8'h00;
            mcand_reg  <= 8'h00;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
            c_reg      <= 1'b0;
            v_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            acc_hi_reg <= acc_hi_next;
            mcand_reg  <= mcand_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            z_reg      <= z_next;
            n_reg      <= n_next;
            c_reg      <= c_next;
            v_reg      <= v_next;
        end
    end

    // Datapath terms shared by the next-state logic.
    always_comb begin
        sum9     = {1'b0, acc_reg} + {1'b0, bus.b};
        diff9    = {1'b0, acc_reg} - {1'b0, bus.b};
        // One multiply step: conditionally add the multiplicand into the high
        // byte, then shift {carry, acc_hi, acc} right so the carry is kept.
        partial9 = acc_reg[0] ? ({1'b0, acc_hi_reg} + {1'b0, mcand_reg})
                              : {1'b0, acc_hi_reg};
        shifted  = {1'b0, partial9, acc_reg[7:1]};
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
        acc_hi_next = acc_hi_reg;
        mcand_next  = mcand_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        z_next      = z_reg;
        n_next      = n_reg;
        c_next      = c_reg;
        v_next      = v_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
                        // acc already holds the multiplier; flags are left alone
                        // until the final step.
                        mcand_next  = bus.b;
                        acc_hi_next = 8'h00;
                        count_next  = 4'd0;
                        busy_next   = 1'b1;
                        state_next  = ST_MUL;
                    end else begin
                        c_next = 1'b0;
                        v_next = 1'b0;
                        case (bus.op)
                            OP_ADD: begin
                                acc_next = sum9[7:0];
                                c_next   = sum9[8];
                                v_next   = (acc_reg[7] == bus.b[7]) &&
                                           (sum9[7] != acc_reg[7]);
                            end
                            OP_SUB: begin
                                acc_next = diff9[7:0];
                                c_next   = diff9[8];  // borrow
                                v_next   = (acc_reg[7] != bus.b[7]) &&
                                           (diff9[7] != acc_reg[7]);
                            end
                            OP_AND:  acc_next = acc_reg & bus.b;
                            OP_OR:   acc_next = acc_reg | bus.b;
                            OP_XOR:  acc_next = acc_reg ^ bus.b;
                            OP_LOAD: acc_next = bus.b;
                            OP_CLR: begin
                                acc_next    = 8'h00;
                                acc_hi_next = 8'h00;
                            end
                            default: acc_next = acc_reg;
                        endcase
                        z_next    = (acc_next == 8'h00);
                        n_next    = acc_next[7];
                        done_next = 1'b1;
                    end
                end
            end

            ST_MUL: begin
                acc_next    = shifted[7:0];
                acc_hi_next = shifted[15:8];
                count_next  = count_reg + 4'd1;
                if (count_reg == 4'd7) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    z_next     = (shifted[15:0] == 16'h0000);
                    n_next     = shifted[15];
                    c_next     = (shifted[15:8] != 8'h00);
                    v_next     = 1'b0;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.acc    = acc_reg;
    assign bus.acc_hi = acc_hi_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.z      = z_reg;
    assign bus.n      = n_reg;
    assign bus.c      = c_reg;
    assign bus.v      = v_reg;

endmodule
